// File: rtl/aux_pkg.sv
// Shared types and codes for the AUX reply collector.
package aux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    STATUS_OK      = 2'b00,
    STATUS_SHORT   = 2'b01,
    STATUS_LONG    = 2'b10,
    STATUS_TIMEOUT = 2'b11
  } status_t;

  localparam logic [3:0] CMD_ACK   = 4'h0;
  localparam logic [3:0] CMD_NACK  = 4'h1;
  localparam logic [3:0] CMD_DEFER = 4'h2;

  // Classify a finished reply from its command nibble and data byte count.
  function automatic status_t classify_reply(input logic [3:0] cmd,
                                             input logic [4:0] count,
                                             input logic [4:0] expected,
                                             input logic [4:0] max_data);
    status_t st;
    if (count > max_data)    st = STATUS_LONG;
    else if (cmd == CMD_ACK) st = (count == expected) ? STATUS_OK :
                                  (count <  expected) ? STATUS_SHORT : STATUS_LONG;
    else                     st = (count == 5'd0) ? STATUS_OK : STATUS_LONG;
    return st;
  endfunction

endpackage

// File: rtl/aux_reply_timer.sv
// Reply-wait timer: clearable, enabled up-counter with a terminal-count flag.
module aux_reply_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 4000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // Clear has priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + W'(1);
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/aux_reply_collector.sv
// AUX reply collector: waits for a reply after a request, forwards data
// bytes and reports a completion status.
// Optional statistics counters are enabled by defining AUX_REPLY_STATS_EN.
module aux_reply_collector
  import aux_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4000,
  parameter int unsigned MAX_DATA       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_start,
  input  logic [4:0] expected_len,
  input  logic [7:0] bdi_aux_in,
  input  logic       bdi_aux_in_vld,
  input  logic       bdi_timer_reset,
  output logic       timer_timeout,
  output logic [3:0] reply_cmd,
  output logic [7:0] reply_data,
  output logic       reply_data_vld,
  output logic       reply_done,
  output logic [1:0] reply_status,
  output logic       busy,
  output logic [7:0] timeout_cnt,
  output logic [7:0] defer_cnt
);

  localparam logic [4:0] MAX_B  = 5'(MAX_DATA);
  localparam logic [4:0] OVER_B = 5'(MAX_DATA + 1);

  state_t     state, state_nxt;
  logic [4:0] count, count_nxt;
  logic [4:0] exp_len, exp_len_nxt;
  logic [3:0] cmd_nxt;
  logic [7:0] data_nxt;
  logic       data_vld_nxt, done_nxt, timeout_nxt;
  logic [1:0] status_nxt;
  logic       timer_clear, timer_en, timer_tc;

  aux_reply_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .enable   (timer_en),
    .terminal (timer_tc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and next-output decode; vld and timer reset both beat timeout.
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    exp_len_nxt  = exp_len;
    cmd_nxt      = reply_cmd;
    data_nxt     = reply_data;
    status_nxt   = reply_status;
    data_vld_nxt = 1'b0;
    done_nxt     = 1'b0;
    timeout_nxt  = 1'b0;
    timer_clear  = 1'b0;
    timer_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_start) begin
          state_nxt   = ST_WAIT;
          timer_clear = 1'b1;
          count_nxt   = '0;
          exp_len_nxt = expected_len;
        end
      end
      ST_WAIT: begin
        timer_en    = 1'b1;
        timer_clear = bdi_timer_reset;
        if (bdi_aux_in_vld) begin
          cmd_nxt   = bdi_aux_in[7:4];
          state_nxt = ST_DATA;
        end else if (!bdi_timer_reset && timer_tc) begin
          timeout_nxt = 1'b1;
          done_nxt    = 1'b1;
          status_nxt  = STATUS_TIMEOUT;
          state_nxt   = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (bdi_aux_in_vld) begin
          if (count < MAX_B) begin
            data_nxt     = bdi_aux_in;
            data_vld_nxt = 1'b1;
            count_nxt    = count + 5'd1;
          end else begin
            count_nxt    = OVER_B;
          end
        end else begin
          done_nxt   = 1'b1;
          status_nxt = classify_reply(reply_cmd, count, exp_len, MAX_B);
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs and reply bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count          <= '0;
      exp_len        <= '0;
      reply_cmd      <= '0;
      reply_data     <= '0;
      reply_data_vld <= 1'b0;
      reply_done     <= 1'b0;
      reply_status   <= '0;
      timer_timeout  <= 1'b0;
      busy           <= 1'b0;
    end else begin
      count          <= count_nxt;
      exp_len        <= exp_len_nxt;
      reply_cmd      <= cmd_nxt;
      reply_data     <= data_nxt;
      reply_data_vld <= data_vld_nxt;
      reply_done     <= done_nxt;
      reply_status   <= status_nxt;
      timer_timeout  <= timeout_nxt;
      busy           <= (state_nxt != ST_IDLE);
    end
  end

`ifdef AUX_REPLY_STATS_EN
  logic defer_end;
  assign defer_end = done_nxt && !timeout_nxt && (reply_cmd == CMD_DEFER);

  // Saturating timeout and DEFER statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_cnt <= '0;
      defer_cnt   <= '0;
    end else begin
      if (timeout_nxt && timeout_cnt != '1) timeout_cnt <= timeout_cnt + 8'd1;
      if (defer_end   && defer_cnt   != '1) defer_cnt   <= defer_cnt + 8'd1;
    end
  end
`else
  assign timeout_cnt = '0;
  assign defer_cnt   = '0;
`endif

endmodule

// File: doc/aux_reply_collector.md
AUX_REPLY_COLLECTOR -- requirements
Module: aux_reply_collector

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 4000, number of clk cycles to wait for a reply before timing out (minimum 2).
REQ-002 Parameter: MAX_DATA, default 16, maximum number of reply data bytes forwarded.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- rx_start  in  1  pulse: request transmission finished; arm the reply wait.
- expected_len  in  5  expected reply data bytes (0..16); captured on rx_start.
- bdi_aux_in  in  8  received byte from the PHY stage.
- bdi_aux_in_vld  in  1  received byte valid; a contiguous high run forms one reply.
- bdi_timer_reset  in  1  restarts the timeout counter.
- timer_timeout  out  1  one-cycle timeout pulse to the PHY stage.
- reply_cmd  out  4  upper nibble of the first reply byte.
- reply_data  out  8  forwarded data byte.
- reply_data_vld  out  1  reply_data valid.
- reply_done  out  1  one-cycle end-of-reply pulse.
- reply_status  out  2  valid with reply_done: 00 OK, 01 SHORT, 10 LONG, 11 TIMEOUT.
- busy  out  1  high whenever state is not IDLE.
- timeout_cnt  out  8  saturating count of timeouts (feature-gated, see Configuration).
- defer_cnt  out  8  saturating count of DEFER replies (feature-gated, see Configuration).

Function
REQ-005 The FSM SHALL have the states IDLE, WAIT, DATA; all outputs are registered.
REQ-006 IDLE: on rx_start, go to WAIT, clear the timer and byte count, and latch expected_len; bytes arriving in IDLE are dropped.
REQ-007 WAIT: the timer increments every cycle and clears to 0 when bdi_timer_reset is high.
REQ-008 WAIT: on the first bdi_aux_in_vld, capture reply_cmd = bdi_aux_in[7:4], go to DATA, and do not forward that byte on reply_data.
REQ-009 WAIT: on the edge sampling timer == TIMEOUT_CYCLES-1 with no vld and no bdi_timer_reset, assert timer_timeout=1, reply_done=1 and reply_status=11 for one cycle, then return to IDLE.
- Timeout therefore occurs TIMEOUT_CYCLES cycles after rx_start.
REQ-010 Simultaneous events: vld beats timeout, and bdi_timer_reset beats timeout; rx_start is ignored outside IDLE.
REQ-011 DATA: each vld byte increments the 5-bit count, which saturates at MAX_DATA+1.
- Bytes 1..MAX_DATA appear on reply_data with reply_data_vld one cycle after being sampled.
- Excess bytes are dropped.
REQ-012 DATA: when vld falls, pulse reply_done on the next edge, return to IDLE, and set reply_status:
- ACK (cmd 0000): OK if count == expected_len, SHORT if count < expected_len, LONG otherwise.
- Any other cmd: OK if count == 0, else LONG.
- Count > MAX_DATA: always LONG.
REQ-013 timer_timeout, reply_data_vld and reply_done SHALL be single-cycle pulses.

Reset
REQ-014 Asserting rst (asynchronously) SHALL force state IDLE and drive every output, counter and the timer to 0.
REQ-015 Reset asserted mid-reply SHALL abort the reply with no reply_done pulse; after release, the block waits for rx_start.

Configuration
REQ-016 The macro AUX_REPLY_STATS_EN controls the statistics counters.
- Defined: timeout_cnt increments on each timeout, and defer_cnt increments on each reply_done with cmd 0010; both saturate at 255.
- Undefined: the counter logic is absent and both ports are tied to 0.

Structure
REQ-017 The shared package aux_pkg SHALL hold the FSM state enum, the reply_status codes, and the reply command codes (ACK 0000, NACK 0001, DEFER 0010).
REQ-018 The timeout counter SHALL be a sub-module, aux_reply_timer, with clear, enable and terminal-count outputs.

Verification
REQ-019 The bench SHALL cover these directed scenarios (TIMEOUT_CYCLES=8):
- ACK with expected_len=4 and 5 bytes (0x00, 0x11, 0x22, 0x33, 0x44) -> data 0x11..0x44 with vld, reply_done, status 00, cmd 0.
- rx_start and no reply -> timer_timeout and reply_done high exactly 8 cycles after rx_start, status 11, timeout_cnt=1 (macro on).
- Timeout: bdi_timer_reset at cycle 6, then silence -> timeout at cycle 14.
- DEFER byte 0x20 alone -> status 00, cmd 2, defer_cnt=1; with the macro off, defer_cnt=0.
- ACK with expected_len=16 and 19 bytes -> 16 data beats, status 10.
- ACK with expected_len=4 and 2 bytes -> status 01.
- rst pulse mid-DATA -> outputs 0, no reply_done; next rx_start operates normally.
